fib_requester: RTL and testbench
================================

// Module: fib_requester
// PURPOSE
//  Initiator-side driver for the fib calculator's req/ack/n/result handshake.
//  Accepts Fibonacci index commands on a valid/ready stream, runs one req/ack
//  transaction per command against the fib responder, and returns F(n) on a
//  valid/ready response stream. Sits between the host command path and the calculator.
// PARAMETERS
//  N_IN     7     width of index n (matches responder)
//  N_OUT    90    width of result (matches responder)
//  TIMEOUT  256   watchdog limit in cycles (used only with FIB_REQ_TIMEOUT_EN)
// PORTS
//  clk         in   1      clock, all logic on rising edge
//  rst         in   1      asynchronous reset, active-high
//  cmd_valid   in   1      command present
//  cmd_ready   out  1      command accepted when valid&ready
//  cmd_n       in   N_IN   requested index
//  req         out  1      to responder: request, registered
//  fib_n       out  N_IN   to responder: index, registered, stable while req=1
//  ack         in   1      from responder
//  result      in   N_OUT  from responder, valid when ack=1
//  rsp_valid   out  1      response present, registered
//  rsp_ready   in   1      downstream accepts response
//  rsp_n       out  N_IN   echo of index for this response
//  rsp_result  out  N_OUT  F(rsp_n)
//  rsp_err     out  1      response aborted by timeout
// BEHAVIOUR
//  Reset (async, active-high): state=IDLE; req=0, fib_n=0, rsp_valid=0, rsp_n=0,
//   rsp_result=0, rsp_err=0; cmd_ready=0 while rst is asserted.
//  States: IDLE, ARM, WAIT_ACK, RESP. cmd_ready = (state==IDLE) and not rst.
//  IDLE: on cmd_valid: latch rsp_n<=cmd_n.
//   cmd_n==0 -> no transaction; rsp_result<=0, rsp_valid<=1 -> RESP.
//   cmd_n!=0 -> fib_n<=cmd_n, req<=1 -> ARM.
//  ARM: hold req=1; wait for ack==0 (responder ack stays high from the previous
//   transaction until it samples the new req). ack==0 -> WAIT_ACK.
//  WAIT_ACK: hold req=1; ack==1 -> rsp_result<=result, req<=0, rsp_valid<=1 -> RESP.
//  RESP: hold rsp_*; rsp_ready -> rsp_valid<=0 -> IDLE.
//   req is therefore low for >=2 edges between transactions, so the responder
//   always observes the falling edge.
//  Back-to-back: a new command is accepted the cycle after the response handshake.
//  Latency n>=1: cmd accept -> rsp_valid = responder compute time + 3 cycles.
//  Outputs change only in the states named above; fib_n is held until the next accept.
//  Mid-operation reset: req drops immediately. The requester and responder share
//   reset; an isolated requester reset can deadlock without the timeout feature.
// CONFIGURATION
//  FIB_REQ_TIMEOUT_EN defined: counter cleared on entry to ARM, increments in
//   ARM/WAIT_ACK. Reaching TIMEOUT -> req<=0, rsp_result<=0, rsp_err<=1,
//   rsp_valid<=1 -> RESP. rsp_err clears when the response is accepted.
//  Not defined: no counter; rsp_err is constant 0; waits indefinitely for ack.
// STRUCTURE
//  fib_pkg: state encoding (IDLE/ARM/WAIT_ACK/RESP), default N_IN/N_OUT,
//   shared with the responder so the widths match.
//  Single module; no sub-module. The watchdog is inline under the ifdef.
// TESTING (bench pairs this block with the fib responder)
//  cmd_n=10, rsp_ready=1 -> rsp_result=55, rsp_n=10, rsp_err=0; req high until ack.
//  cmd_n=1 then cmd_n=2 back-to-back -> results 1, 1; second transaction passes
//   ARM only after ack falls.
//  cmd_n=0 -> rsp_result=0 within 1 cycle of accept; req never asserted.
//  cmd_n=90 with rsp_ready held low 20 cycles -> rsp_valid and rsp_result
//   (2880067194370816120) stable; cmd_ready=0 until accepted.
//  rst pulsed while in WAIT_ACK -> req, rsp_valid, rsp_err low the same cycle; the
//   next cmd_n=5 returns 5.
//  FIB_REQ_TIMEOUT_EN, TIMEOUT=16, ack tied 0 -> rsp_err=1, rsp_result=0 after 16
//   cycles, req=0.

Source files
------------

// File: rtl/fib_pkg.sv
// Shared definitions for the fib requester and the fib responder: requester
// state encoding and the default index/result widths, so both sides agree.
package fib_pkg;

  localparam int FIB_N_IN  = 7;
  localparam int FIB_N_OUT = 90;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARM      = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_RESP     = 2'd3
  } fib_state_e;

endpackage : fib_pkg

// File: rtl/fib_requester_if.sv
// Bundle of the three handshakes around the fib requester: host command
// stream, req/ack link to the responder, and the response stream.
// master = requester side, slave = surrounding environment.
interface fib_requester_if
  import fib_pkg::*;
#(
  parameter int N_IN  = FIB_N_IN,
  parameter int N_OUT = FIB_N_OUT
);

  // Command stream
  logic             cmd_valid;
  logic             cmd_ready;
  logic [N_IN-1:0]  cmd_n;

  // Responder link
  logic             req;
  logic [N_IN-1:0]  fib_n;
  logic             ack;
  logic [N_OUT-1:0] result;

  // Response stream
  logic             rsp_valid;
  logic             rsp_ready;
  logic [N_IN-1:0]  rsp_n;
  logic [N_OUT-1:0] rsp_result;
  logic             rsp_err;

  modport master (
    input  cmd_valid, cmd_n, ack, result, rsp_ready,
    output cmd_ready, req, fib_n, rsp_valid, rsp_n, rsp_result, rsp_err
  );

  modport slave (
    output cmd_valid, cmd_n, ack, result, rsp_ready,
    input  cmd_ready, req, fib_n, rsp_valid, rsp_n, rsp_result, rsp_err
  );

endinterface : fib_requester_if

// File: rtl/fib_requester.sv
// Initiator for the fib calculator: takes an index command, runs one req/ack
// transaction with the responder and returns F(n) on the response stream.
// Index 0 is answered locally without touching the responder.
// Optional watchdog: define FIB_REQ_TIMEOUT_EN to abort a transaction after
// TIMEOUT cycles in ARM/WAIT_ACK with rsp_err=1 and rsp_result=0.
module fib_requester
  import fib_pkg::*;
#(
  parameter int N_IN    = FIB_N_IN,
  parameter int N_OUT   = FIB_N_OUT,
  parameter int TIMEOUT = 256
) (
  input  logic            clk,
  input  logic            rst,
  fib_requester_if.master bus
);

  fib_state_e       state_q, state_d;
  logic             req_q, req_d;
  logic [N_IN-1:0]  fib_n_q, fib_n_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [N_IN-1:0]  rsp_n_q, rsp_n_d;
  logic [N_OUT-1:0] rsp_result_q, rsp_result_d;
  logic             timeout_hit;

`ifdef FIB_REQ_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rsp_err_q, rsp_err_d;

  // Last cycle of the watchdog window: abort at this edge
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign bus.rsp_err = rsp_err_q;
`else
  assign timeout_hit = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  // Command is only taken in IDLE, and never while reset is held
  assign bus.cmd_ready  = (state_q == ST_IDLE) && !rst;
  assign bus.req        = req_q;
  assign bus.fib_n      = fib_n_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_n      = rsp_n_q;
  assign bus.rsp_result = rsp_result_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Registered outputs toward responder and response stream
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q        <= 1'b0;
      fib_n_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_n_q      <= '0;
      rsp_result_q <= '0;
`ifdef FIB_REQ_TIMEOUT_EN
      cnt_q        <= '0;
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      req_q        <= req_d;
      fib_n_q      <= fib_n_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_n_q      <= rsp_n_d;
      rsp_result_q <= rsp_result_d;
`ifdef FIB_REQ_TIMEOUT_EN
      cnt_q        <= cnt_d;
      rsp_err_q    <= rsp_err_d;
`endif
    end
  end

  // Next-state and output decode; everything holds unless a state acts on it
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    fib_n_d      = fib_n_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_n_d      = rsp_n_q;
    rsp_result_d = rsp_result_q;
`ifdef FIB_REQ_TIMEOUT_EN
    cnt_d        = cnt_q;
    rsp_err_d    = rsp_err_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          rsp_n_d = bus.cmd_n;
          if (bus.cmd_n == '0) begin
            // F(0) = 0: answer directly, responder stays untouched
            rsp_result_d = '0;
            rsp_valid_d  = 1'b1;
            state_d      = ST_RESP;
          end else begin
            fib_n_d = bus.cmd_n;
            req_d   = 1'b1;
            state_d = ST_ARM;
`ifdef FIB_REQ_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end

      ST_ARM: begin
        // ack may still be high from the previous transaction; wait for the
        // responder to take the new req and drop it before trusting ack
        if (!bus.ack) begin
          state_d = ST_WAIT_ACK;
        end
`ifdef FIB_REQ_TIMEOUT_EN
        cnt_d = cnt_q + CNT_W'(1);
`endif
      end

      ST_WAIT_ACK: begin
        if (bus.ack) begin
          rsp_result_d = bus.result;
          req_d        = 1'b0;
          rsp_valid_d  = 1'b1;
          state_d      = ST_RESP;
        end
`ifdef FIB_REQ_TIMEOUT_EN
        cnt_d = cnt_q + CNT_W'(1);
`endif
      end

      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
`ifdef FIB_REQ_TIMEOUT_EN
          rsp_err_d   = 1'b0;
`endif
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Watchdog abort; a real ack arriving on the same edge still wins
    if (timeout_hit &&
        ((state_q == ST_ARM) || ((state_q == ST_WAIT_ACK) && !bus.ack))) begin
      req_d        = 1'b0;
      rsp_result_d = '0;
      rsp_valid_d  = 1'b1;
      state_d      = ST_RESP;
`ifdef FIB_REQ_TIMEOUT_EN
      rsp_err_d    = 1'b1;
`endif
    end
  end

endmodule : fib_requester

// File: tb/tb_fib_requester.sv
// Bench for fib_requester paired with a behavioural fib responder.
module tb_fib_requester;
  import fib_pkg::*;

  localparam int N_IN    = FIB_N_IN;
  localparam int N_OUT   = FIB_N_OUT;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fib_requester_if #(.N_IN(N_IN), .N_OUT(N_OUT)) bus ();

  fib_requester #(.N_IN(N_IN), .N_OUT(N_OUT), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference: F(n) by straightforward iteration
  function automatic logic [N_OUT-1:0] fib_ref(input int n);
    logic [N_OUT-1:0] a, b, t;
    a = '0;
    b = N_OUT'(1);
    for (int i = 0; i < n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Behavioural responder: takes a fresh req, drops ack, computes for
  // resp_delay cycles, then raises ack with F(n) and holds it until the next req
  logic             ack_r;
  logic [N_OUT-1:0] res_r;
  logic             busy, armed;
  int               cnt;
  logic [N_IN-1:0]  n_lat;
  int               resp_delay;
  logic             ack_stuck0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_r <= 1'b0;
      res_r <= '0;
      busy  <= 1'b0;
      armed <= 1'b1;
      cnt   <= 0;
      n_lat <= '0;
    end else begin
      if (busy) begin
        if (cnt == 0) begin
          ack_r <= 1'b1;
          res_r <= fib_ref(int'(n_lat));
          busy  <= 1'b0;
        end else begin
          cnt <= cnt - 1;
        end
      end else if (bus.req && armed) begin
        ack_r <= 1'b0;
        res_r <= N_OUT'({$urandom, $urandom, $urandom});
        busy  <= 1'b1;
        cnt   <= resp_delay;
        n_lat <= bus.fib_n;
        armed <= 1'b0;
      end
      if (!bus.req) armed <= 1'b1;
    end
  end

  assign bus.ack    = ack_stuck0 ? 1'b0 : ack_r;
  assign bus.result = res_r;

  // Drive one command; return edges from accept to rsp_valid
  task automatic run_cmd(input int n, output int lat, output bit req_ok, output bit tmo);
    int t;
    tmo = 0;
    req_ok = 1;
    bus.cmd_valid = 1'b1;
    bus.cmd_n = N_IN'(n);
    t = 0;
    while (bus.cmd_ready !== 1'b1 && t < 100) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 100) tmo = 1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_n = N_IN'($urandom);
    lat = 0;
    while (bus.rsp_valid !== 1'b1 && lat < 300) begin
      if (n != 0 && bus.req !== 1'b1) req_ok = 0;
      @(posedge clk); #1; lat++;
    end
    if (lat >= 300) tmo = 1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready got=%b exp=0", bus.cmd_ready); end
    checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", bus.req); end
    checks++; if (bus.fib_n !== '0) begin errors++; $display("FAIL reset_fib_n got=%0d exp=0", bus.fib_n); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); end
    checks++; if (bus.rsp_n !== '0 || bus.rsp_result !== '0 || bus.rsp_err !== 1'b0) begin
      errors++; $display("FAIL reset_rsp_data got n=%0d res=%0d err=%b exp 0/0/0", bus.rsp_n, bus.rsp_result, bus.rsp_err);
    end
    rst = 1'b0;
    #1;
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_release_cmd_ready got=%b exp=1", bus.cmd_ready); end
  endtask

  task automatic test_single();
    int lat; bit rok, tmo;
    resp_delay = 4;
    bus.rsp_ready = 1'b1;
    run_cmd(10, lat, rok, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL single_timeout got=timeout exp=response"); end
    checks++; if (bus.rsp_result !== N_OUT'(55)) begin errors++; $display("FAIL single_result got=%0d exp=55", bus.rsp_result); end
    checks++; if (bus.rsp_n !== N_IN'(10)) begin errors++; $display("FAIL single_rsp_n got=%0d exp=10", bus.rsp_n); end
    checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL single_err got=%b exp=0", bus.rsp_err); end
    checks++; if (!rok) begin errors++; $display("FAIL single_req_held got=dropped exp=held"); end
    checks++; if (lat != 4 + 3) begin errors++; $display("FAIL single_latency got=%0d exp=%0d", lat, 4 + 3); end
    checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL single_req_after got=%b exp=0", bus.req); end
    @(posedge clk); #1;
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_rsp_drop got=%b exp=0", bus.rsp_valid); end
  endtask

  task automatic test_back_to_back();
    int lat; bit rok, tmo;
    bus.rsp_ready = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      resp_delay = k + 1;
      run_cmd(k, lat, rok, tmo);
      checks++; if (tmo || bus.rsp_result !== N_OUT'(1)) begin
        errors++; $display("FAIL b2b_result_%0d got=%0d exp=1", k, bus.rsp_result);
      end
      checks++; if (lat != resp_delay + 3) begin errors++; $display("FAIL b2b_latency_%0d got=%0d exp=%0d", k, lat, resp_delay + 3); end
      @(posedge clk); #1;
      checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_%0d got=%b exp=1", k, bus.cmd_ready); end
    end
  endtask

  task automatic test_zero();
    int lat; bit rok, tmo;
    bus.rsp_ready = 1'b1;
    run_cmd(0, lat, rok, tmo);
    checks++; if (lat != 0 || bus.rsp_result !== '0 || bus.rsp_n !== '0) begin
      errors++; $display("FAIL zero_rsp got lat=%0d res=%0d n=%0d exp 0/0/0", lat, bus.rsp_result, bus.rsp_n);
    end
    checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL zero_req got=%b exp=0", bus.req); end
    @(posedge clk); #1;
    checks++; if (bus.req !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL zero_after got req=%b vld=%b exp 0/0", bus.req, bus.rsp_valid);
    end
  endtask

  task automatic test_stall();
    int lat; bit rok, tmo;
    logic [N_OUT-1:0] exp90;
    exp90 = N_OUT'(64'd2880067194370816120);
    resp_delay = 2;
    bus.rsp_ready = 1'b0;
    run_cmd(90, lat, rok, tmo);
    checks++; if (tmo || bus.rsp_result !== exp90) begin errors++; $display("FAIL stall_result got=%0d exp=%0d", bus.rsp_result, exp90); end
    bus.cmd_valid = 1'b1;
    bus.cmd_n = N_IN'(3);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== exp90 || bus.rsp_n !== N_IN'(90) || bus.cmd_ready !== 1'b0) begin
        errors++; $display("FAIL stall_hold_%0d got vld=%b res=%0d n=%0d rdy=%b", i, bus.rsp_valid, bus.rsp_result, bus.rsp_n, bus.cmd_ready);
      end
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL stall_release got vld=%b rdy=%b exp 0/1", bus.rsp_valid, bus.cmd_ready);
    end
  endtask

  task automatic test_reset_mid();
    int lat; bit rok, tmo;
    resp_delay = 30;
    bus.rsp_ready = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_n = N_IN'(40);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (bus.req !== 1'b1 || bus.ack !== 1'b0) begin
      errors++; $display("FAIL midrst_pre got req=%b ack=%b exp 1/0", bus.req, bus.ack);
    end
    #3 rst = 1'b1;
    #1;
    checks++; if (bus.req !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0 || bus.cmd_ready !== 1'b0) begin
      errors++; $display("FAIL midrst_outputs got req=%b vld=%b err=%b rdy=%b exp 0/0/0/0", bus.req, bus.rsp_valid, bus.rsp_err, bus.cmd_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    resp_delay = 1;
    run_cmd(5, lat, rok, tmo);
    checks++; if (tmo || bus.rsp_result !== N_OUT'(5) || bus.rsp_n !== N_IN'(5)) begin
      errors++; $display("FAIL midrst_next got res=%0d n=%0d exp 5/5", bus.rsp_result, bus.rsp_n);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int lat, n, stall, exp_lat; bit rok, tmo;
    logic [N_OUT-1:0] exp_r;
    for (int it = 0; it < 24; it++) begin
      n = $urandom_range(0, 90);
      resp_delay = $urandom_range(0, 6);
      stall = $urandom_range(0, 3);
      exp_r = fib_ref(n);
      exp_lat = (n == 0) ? 0 : resp_delay + 3;
      bus.rsp_ready = (stall == 0);
      run_cmd(n, lat, rok, tmo);
      checks++; if (tmo || bus.rsp_result !== exp_r || bus.rsp_n !== N_IN'(n) || bus.rsp_err !== 1'b0) begin
        errors++; $display("FAIL rand_%0d_rsp got res=%0d n=%0d err=%b exp res=%0d n=%0d err=0", it, bus.rsp_result, bus.rsp_n, bus.rsp_err, exp_r, n);
      end
      checks++; if (lat != exp_lat || !rok) begin
        errors++; $display("FAIL rand_%0d_timing got lat=%0d req_ok=%0b exp lat=%0d req_ok=1", it, lat, rok, exp_lat);
      end
      repeat (stall) @(posedge clk);
      #1;
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== exp_r) begin
        errors++; $display("FAIL rand_%0d_hold got vld=%b res=%0d exp vld=1 res=%0d", it, bus.rsp_valid, bus.rsp_result, exp_r);
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rand_%0d_drop got=%b exp=0", it, bus.rsp_valid); end
    end
  endtask

  task automatic test_timeout();
`ifdef FIB_REQ_TIMEOUT_EN
    int lat; bit rok, tmo;
    ack_stuck0 = 1'b1;
    resp_delay = 2;
    bus.rsp_ready = 1'b0;
    run_cmd(7, lat, rok, tmo);
    checks++; if (tmo || lat != TIMEOUT) begin errors++; $display("FAIL timeout_latency got=%0d exp=%0d", lat, TIMEOUT); end
    checks++; if (bus.rsp_err !== 1'b1 || bus.rsp_result !== '0 || bus.req !== 1'b0) begin
      errors++; $display("FAIL timeout_rsp got err=%b res=%0d req=%b exp 1/0/0", bus.rsp_err, bus.rsp_result, bus.req);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.rsp_err !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL timeout_clear got err=%b vld=%b exp 0/0", bus.rsp_err, bus.rsp_valid);
    end
    ack_stuck0 = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=hang exp=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_n = '0;
    bus.rsp_ready = 1'b1;
    ack_stuck0 = 1'b0;
    resp_delay = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_zero();
    test_stall();
    test_reset_mid();
    test_random();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_fib_requester
